// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the execute-stage iterative multiplier and divider.
//
// Contents:
//   XLEN      - operand / result width (32; the datapaths only support 32)
//   CNT_W     - width of the iteration counter (log2 of XLEN)
//   mulsel_e  - RV32M multiply select: MUL, MULH, MULHSU, MULHU
//   divsel_e  - RV32M divide select:   DIV, DIVU, REM, REMU
//               (kept here so multiply and divide can later share one alusel)
//   state_e   - iterative-unit FSM states: IDLE, CALC, DONE
//   Helpers   - selects the product word and identifies the signed operands
//               for a multiply select.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // Encodings follow funct3[1:0] of the corresponding RV32M instructions.
  typedef enum logic [1:0] {
    MUL    = 2'b00,  // low word, identical for signed and unsigned operands
    MULH   = 2'b01,  // high word, signed x signed
    MULHSU = 2'b10,  // high word, signed x unsigned
    MULHU  = 2'b11   // high word, unsigned x unsigned
  } mulsel_e;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } divsel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Every select except MUL returns the upper half of the 64-bit product.
  function automatic logic sel_high_word(input mulsel_e sel);
    return (sel != MUL);
  endfunction

  // The multiplicand (rs1) is treated as signed by MULH and MULHSU.
  function automatic logic sel_a_signed(input mulsel_e sel);
    return (sel == MULH) || (sel == MULHSU);
  endfunction

  // The multiplier (rs2) is treated as signed only by MULH.
  function automatic logic sel_b_signed(input mulsel_e sel);
    return (sel == MULH);
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// -----------------------------------------------------------------------------
// mul_sign_fix
// Combinational sign handling around an unsigned magnitude core.
// The multiplier (and later the divider) works on operand magnitudes; this
// block strips the signs on the way in and re-applies the result sign on
// the way out.
//
// Ports:
//   i_a      [XLEN-1:0]   rs1 operand
//   i_b      [XLEN-1:0]   rs2 operand
//   i_sel    mulsel_e     operation select (decides which operands are signed)
//   i_prod   [2*XLEN-1:0] unsigned magnitude result from the core
//   i_neg    1            sign of the in-flight result (registered by the core)
//   o_mcand  [XLEN-1:0]   |rs1| (rs1 unchanged when treated as unsigned)
//   o_mplier [XLEN-1:0]   |rs2| (rs2 unchanged when treated as unsigned)
//   o_neg    1            result sign for the current operands
//   o_final  [2*XLEN-1:0] i_prod, two's-complement negated when i_neg is set
// -----------------------------------------------------------------------------
module mul_sign_fix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  input  mulsel_e           i_sel,
  input  logic [2*XLEN-1:0] i_prod,
  input  logic              i_neg,
  output logic [XLEN-1:0]   o_mcand,
  output logic [XLEN-1:0]   o_mplier,
  output logic              o_neg,
  output logic [2*XLEN-1:0] o_final
);

  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = i_a[XLEN-1] & sel_a_signed(i_sel);
  assign w_b_neg = i_b[XLEN-1] & sel_b_signed(i_sel);

  // The magnitude of 0x80000000 wraps back to 0x80000000, which is exactly
  // 2^31 when read as unsigned, so the most-negative value needs no special
  // case anywhere downstream.
  assign o_mcand  = w_a_neg ? (~i_a + 1'b1) : i_a;
  assign o_mplier = w_b_neg ? (~i_b + 1'b1) : i_b;
  assign o_neg    = w_a_neg ^ w_b_neg;

  // A full 64-bit negate keeps the low word correct as well, so MUL needs no
  // signed/unsigned distinction.
  assign o_final = i_neg ? (~i_prod + 1'b1) : i_prod;

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// It sits beside the sequential divider in the execute stage; the pipeline
// stalls while busy is high.
//
// Operation:
//   A one-cycle valid strobe latches a, b and mulsel (in any state; a strobe
//   while busy aborts the in-flight operation). The unsigned magnitudes are
//   multiplied over 32 CALC cycles, one multiplier bit per cycle, then the
//   sign is re-applied and the selected word is registered into res on
//   entry to DONE. ready pulses for the single DONE cycle. res then holds
//   until the next completed operation.
//   Latency: valid on cycle N -> ready/res on cycle N+33, busy on N+1..N+32.
//
// Build option (macro SEQ_MUL_EARLY_OUT_EN):
//   Defined   - CALC ends as soon as the multiplier bits still to be consumed
//               are all zero. The partial product is right-aligned with one
//               barrel shift. Latency becomes 2 + index of the highest set
//               bit of |b| (minimum 2). Results are bit-identical.
//   Undefined - fixed 33-cycle latency, no barrel shifter.
//
// Ports:
//   clk     in   1     system clock, rising edge
//   rst     in   1     asynchronous reset, active high
//   a       in   XLEN  multiplicand (rs1), sampled on the valid cycle
//   b       in   XLEN  multiplier (rs2), sampled on the valid cycle
//   valid   in   1     start strobe
//   mulsel  in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   busy    out  1     high while the product is being accumulated
//   ready   out  1     one-cycle pulse, res valid on this cycle
//   res     out  XLEN  selected product word
// -----------------------------------------------------------------------------
module seq_multiplier
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            valid,
  input  logic [1:0]      mulsel,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] res
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e            r_state;
  logic [2*XLEN-1:0] r_prod;   // {partial sum, unconsumed multiplier bits}
  logic [XLEN-1:0]   r_mcand;  // |a|
  logic              r_neg;    // result sign
  mulsel_e           r_sel;
  logic [CNT_W-1:0]  r_count;  // shift steps left after the current one
  logic [XLEN-1:0]   r_res;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_e            w_state_next;
  mulsel_e           w_sel_in;
  logic [XLEN-1:0]   w_mcand;
  logic [XLEN-1:0]   w_mplier;
  logic              w_neg;
  logic [XLEN:0]     w_sum;        // carry out of the add is kept
  logic [2*XLEN-1:0] w_shift;      // r_prod after one shift-add step
  logic [2*XLEN-1:0] w_prod_done;  // right-aligned magnitude product
  logic [2*XLEN-1:0] w_final;      // signed product
  logic              w_last;
  logic              w_early;
  logic              w_finish;

  assign w_sel_in = mulsel_e'(mulsel);

  // ---------------------------------------------------------------------------
  // Sign handling: operand magnitudes on capture, result negate on completion
  // ---------------------------------------------------------------------------
  mul_sign_fix u_sign_fix (
    .i_a      (a),
    .i_b      (b),
    .i_sel    (w_sel_in),
    .i_prod   (w_prod_done),
    .i_neg    (r_neg),
    .o_mcand  (w_mcand),
    .o_mplier (w_mplier),
    .o_neg    (w_neg),
    .o_final  (w_final)
  );

  // ---------------------------------------------------------------------------
  // Shift-add step
  // Bit 0 of r_prod is the next multiplier bit. The 33-bit sum replaces the
  // upper half, and the whole 65-bit value shifts right by one, so the carry
  // lands in bit 63 instead of being lost.
  // ---------------------------------------------------------------------------
  assign w_sum   = {1'b0, r_prod[2*XLEN-1:XLEN]}
                 + (r_prod[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
  assign w_shift = {w_sum, r_prod[XLEN-1:1]};
  assign w_last  = (r_count == '0);

`ifdef SEQ_MUL_EARLY_OUT_EN
  // After the step at count c, w_shift[c-1:0] are the c multiplier bits still
  // to be consumed. Once they are all zero, the remaining c steps would only
  // shift right without adding, so those steps collapse into a single shift
  // by c.
  logic [2*XLEN-1:0] w_rem_mask;

  assign w_rem_mask  = ({{(2*XLEN-1){1'b0}}, 1'b1} << r_count) - 1'b1;
  assign w_early     = !w_last && ((w_shift & w_rem_mask) == '0);
  assign w_prod_done = w_early ? (w_shift >> r_count) : w_shift;
`else
  assign w_early     = 1'b0;
  assign w_prod_done = w_shift;
`endif

  assign w_finish = w_last || w_early;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so that every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // A new valid always wins. It restarts the operation from CALC, which also
  // aborts an in-flight operation before it reaches DONE. ready is a decode
  // of DONE, so a valid on the DONE cycle still lets that pulse through.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_next = r_state;
    busy         = 1'b0;
    ready        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (valid) begin
          w_state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (valid) begin
          w_state_next = CALC;
        end else if (w_finish) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        ready        = 1'b1;
        w_state_next = valid ? CALC : IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // res is loaded only on the CALC -> DONE transition. Loading it there, from
  // the final step's combinational result, makes it valid on the same cycle
  // that ready pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_neg   <= 1'b0;
      r_sel   <= MUL;
      r_count <= '0;
      r_res   <= '0;
    end else if (valid) begin
      r_prod  <= {{XLEN{1'b0}}, w_mplier};
      r_mcand <= w_mcand;
      r_neg   <= w_neg;
      r_sel   <= w_sel_in;
      r_count <= '1;
    end else if (r_state == CALC) begin
      r_prod  <= w_prod_done;
      r_count <= r_count - 1'b1;
      if (w_finish) begin
        r_res <= sel_high_word(r_sel) ? w_final[2*XLEN-1:XLEN]
                                      : w_final[XLEN-1:0];
      end
    end
  end

  assign res = r_res;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Directed self-checking bench for seq_multiplier. It tracks the
// SEQ_MUL_EARLY_OUT_EN build option when computing expected latencies.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

`ifdef SEQ_MUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        rst    = 1'b1;
  logic [31:0] a      = '0;
  logic [31:0] b      = '0;
  logic        valid  = 1'b0;
  logic [1:0]  mulsel = 2'b00;
  logic        busy;
  logic        ready;
  logic [31:0] res;

  int checks    = 0;
  int failures  = 0;
  int ready_cnt = 0;

  seq_multiplier dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .valid  (valid),
    .mulsel (mulsel),
    .busy   (busy),
    .ready  (ready),
    .res    (res)
  );

  always #5 clk = ~clk;

  // Counts every ready pulse, used for the abort and reset scenarios.
  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product via sign-extended 64-bit multiply.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] sel);
    logic [63:0] ex;
    logic [63:0] ey;
    logic [63:0] p;
    ex = (sel == 2'b01 || sel == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
    ey = (sel == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
    p  = ex * ey;
    return (sel == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Cycles from valid to ready.
  function automatic int exp_lat(input logic [31:0] y, input logic [1:0] sel);
    logic [31:0] m;
    int hi;
    m  = (sel == 2'b01 && y[31]) ? (~y + 32'd1) : y;
    hi = 0;
    for (int i = 0; i < 32; i++) if (m[i]) hi = i;
    return EARLY ? 2 + hi : 33;
  endfunction

  // Presents one valid cycle. Returns #1 into cycle N+1 with the operand
  // inputs scrambled to show they are not re-sampled.
  task automatic start(input logic [31:0] x, input logic [31:0] y, input logic [1:0] sel);
    @(posedge clk); #1;
    a = x; b = y; mulsel = sel; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; a = ~x; b = ~y; mulsel = ~sel;
  endtask

  // Samples at each negedge from cycle N+1. lat is the cycle offset of ready
  // (-1 on timeout); busy_ok clears if busy drops before ready.
  task automatic wait_ready(output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] sel, input logic [31:0] exp);
    int lat;
    bit bok;
    start(x, y, sel);
    wait_ready(lat, bok);
    check({tag, " latency"}, lat, exp_lat(y, sel));
    check({tag, " busy"}, bok, 1'b1);
    check({tag, " res"}, res, exp);
    check({tag, " busy_at_ready"}, busy, 1'b0);
    @(negedge clk);
    check({tag, " ready_pulse"}, ready, 1'b0);
    check({tag, " res_hold"}, res, exp);
  endtask

  initial begin
    int lat;
    bit bok;
    int cnt0;
    logic [31:0] rx;
    logic [31:0] ry;
    logic [1:0]  rs;

    // Reset state
    #12;
    check("reset busy", busy, 1'b0);
    check("reset ready", ready, 1'b0);
    check("reset res", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-computed results
    run_op("mul_7x6",       32'd7,         32'd6,         2'b00, 32'h0000002A);
    run_op("mulh_m1xm1",    32'hFFFFFFFF,  32'hFFFFFFFF,  2'b01, 32'h00000000);
    run_op("mulhu_m1xm1",   32'hFFFFFFFF,  32'hFFFFFFFF,  2'b11, 32'hFFFFFFFE);
    run_op("mulhsu_m1xm1",  32'hFFFFFFFF,  32'hFFFFFFFF,  2'b10, 32'hFFFFFFFF);
    run_op("mulh_min",      32'h80000000,  32'h80000000,  2'b01, 32'h40000000);
    run_op("mul_min",       32'h80000000,  32'h80000000,  2'b00, 32'h00000000);
    run_op("mulhsu_min",    32'h80000000,  32'h80000000,  2'b10, 32'hC0000000);
    run_op("mul_m7x6",      32'hFFFFFFF9,  32'd6,         2'b00, 32'hFFFFFFD6);
    run_op("mulh_m7x6",     32'hFFFFFFF9,  32'd6,         2'b01, 32'hFFFFFFFF);
    run_op("mulh_6xm7",     32'd6,         32'hFFFFFFF9,  2'b01, 32'hFFFFFFFF);
    run_op("mulhu_beef",    32'hDEADBEEF,  32'h00000010,  2'b11, 32'h0000000D);
    run_op("mul_bx1",       32'h00001234,  32'd1,         2'b00, 32'h00001234);
    run_op("mulh_bx0",      32'd5,         32'd0,         2'b01, 32'h00000000);

    // Random pairs in all four modes against the reference product
    for (int i = 0; i < 48; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 4 == 1) ry = ry >> (i % 29);
      rs = 2'(i);
      run_op($sformatf("rand%0d", i), rx, ry, rs, ref_mul(rx, ry, rs));
    end

    // valid on the DONE cycle: the finishing ready still fires, next op runs
    start(32'd9, 32'd9, 2'b00);
    repeat (exp_lat(32'd9, 2'b00) - 1) @(posedge clk);
    #1;
    a = 32'hFFFFFFFF; b = 32'd2; mulsel = 2'b11; valid = 1'b1;
    @(negedge clk);
    check("done_valid ready", ready, 1'b1);
    check("done_valid res", res, 32'd81);
    @(posedge clk); #1;
    valid = 1'b0; a = '0; b = '0;
    wait_ready(lat, bok);
    check("done_valid next latency", lat, exp_lat(32'd2, 2'b11));
    check("done_valid next res", res, 32'h00000001);

    // Abort/restart at N+10: exactly one ready, for the second operation
    @(posedge clk); #1;
    cnt0 = ready_cnt;
    start(32'd3, 32'h80000005, 2'b00);
    repeat (9) @(posedge clk);
    #1;
    a = 32'h00010000; b = 32'h00010000; mulsel = 2'b11; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; a = '0; b = '0;
    wait_ready(lat, bok);
    check("abort latency", lat, exp_lat(32'h00010000, 2'b11));
    check("abort res", res, 32'h00000001);
    repeat (3) @(posedge clk);
    #1;
    check("abort ready count", ready_cnt, cnt0 + 1);

    // Asynchronous reset at N+15 mid-CALC
    start(32'h12345678, 32'hFFFFFFFF, 2'b00);
    repeat (14) @(posedge clk);
    #2;
    check("midcalc busy before rst", busy, 1'b1);
    cnt0 = ready_cnt;
    rst  = 1'b1;
    #1;
    check("midcalc rst busy", busy, 1'b0);
    check("midcalc rst ready", ready, 1'b0);
    check("midcalc rst res", res, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midcalc no ready", ready_cnt, cnt0);
    check("midcalc idle busy", busy, 1'b0);

    // Normal operation after reset
    run_op("post_rst_3x4", 32'd3, 32'd4, 2'b00, 32'h0000000C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
